// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter_if
// Brief    : Two requester ports plus one result port for the shared ALU arbiter.
// Revision : 1.0
// ============================================================================
interface alu_arbiter_if;
  logic        a_valid;
  logic        a_ready;
  logic [31:0] a_op1;
  logic [31:0] a_op2;
  logic [3:0]  a_alu_op;

  logic        b_valid;
  logic        b_ready;
  logic [31:0] b_op1;
  logic [31:0] b_op2;
  logic [3:0]  b_alu_op;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_branch;
  logic        out_id;

  logic [15:0] cnt_a;
  logic [15:0] cnt_b;

  modport slave (
    input  a_valid, a_op1, a_op2, a_alu_op,
    input  b_valid, b_op1, b_op2, b_alu_op,
    input  out_ready,
    output a_ready, b_ready,
    output out_valid, out_result, out_branch, out_id,
    output cnt_a, cnt_b
  );

  modport master (
    output a_valid, a_op1, a_op2, a_alu_op,
    output b_valid, b_op1, b_op2, b_alu_op,
    output out_ready,
    input  a_ready, b_ready,
    input  out_valid, out_result, out_branch, out_id,
    input  cnt_a, cnt_b
  );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Brief    : Round-robin sharing of one combinational ALU between two
//            requesters, with a single registered result slot and per-
//            requester completion counters.
// Revision : 1.0
// ============================================================================
module alu_arbiter (
  input  wire logic     clk,
  input  wire logic     rst,
  alu_arbiter_if.slave  bus
);

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } grant_t;

  localparam logic [3:0] c_op_add = 4'd0;
  localparam logic [3:0] c_op_sub = 4'd1;
  localparam logic [3:0] c_op_and = 4'd2;
  localparam logic [3:0] c_op_or  = 4'd3;
  localparam logic [3:0] c_op_xor = 4'd4;
  localparam logic [3:0] c_op_gt  = 4'd5;
  localparam logic [3:0] c_op_lt  = 4'd6;
  localparam logic [3:0] c_op_srl = 4'd7;
  localparam logic [3:0] c_op_sll = 4'd8;

  grant_t      r_last_grant;
  logic        r_out_valid;
  logic [31:0] r_out_result;
  logic        r_out_branch;
  logic        r_out_id;
  logic [15:0] r_cnt_a;
  logic [15:0] r_cnt_b;

  logic        w_can_accept;
  logic        w_grant_a;
  logic        w_grant_b;
  logic        w_grant_any;
  logic        w_drain;
  logic [31:0] w_sel_op1;
  logic [31:0] w_sel_op2;
  logic [3:0]  w_sel_op;
  logic [31:0] w_alu_result;
  logic        w_alu_branch;

  // Grants are held off while reset is asserted even though the slot is empty.
  assign w_can_accept = !rst && (!r_out_valid || bus.out_ready);
  assign w_drain      = r_out_valid && bus.out_ready;

  always_comb begin
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    if (w_can_accept) begin
      if (bus.a_valid && bus.b_valid) begin
        if (r_last_grant == GNT_B) begin
          w_grant_a = 1'b1;
        end else begin
          w_grant_b = 1'b1;
        end
      end else if (bus.a_valid) begin
        w_grant_a = 1'b1;
      end else if (bus.b_valid) begin
        w_grant_b = 1'b1;
      end
    end
  end

  assign w_grant_any = w_grant_a || w_grant_b;

  assign w_sel_op1 = w_grant_b ? bus.b_op1    : bus.a_op1;
  assign w_sel_op2 = w_grant_b ? bus.b_op2    : bus.a_op2;
  assign w_sel_op  = w_grant_b ? bus.b_alu_op : bus.a_alu_op;

  always_comb begin
    w_alu_result = 32'd0;
    w_alu_branch = 1'b0;
    case (w_sel_op)
      c_op_add: w_alu_result = w_sel_op1 + w_sel_op2;
      c_op_sub: w_alu_result = w_sel_op1 - w_sel_op2;
      c_op_and: w_alu_result = w_sel_op1 & w_sel_op2;
      c_op_or:  w_alu_result = w_sel_op1 | w_sel_op2;
      c_op_xor: w_alu_result = w_sel_op1 ^ w_sel_op2;
      c_op_gt: begin
        w_alu_branch = (w_sel_op1 > w_sel_op2);
        w_alu_result = {31'd0, w_alu_branch};
      end
      c_op_lt: begin
        w_alu_branch = (w_sel_op1 < w_sel_op2);
        w_alu_result = {31'd0, w_alu_branch};
      end
      // Whole op2 is the shift amount; anything past 31 empties the word.
      c_op_srl: w_alu_result = (w_sel_op2 > 32'd31) ? 32'd0 : (w_sel_op1 >> w_sel_op2[4:0]);
      c_op_sll: w_alu_result = (w_sel_op2 > 32'd31) ? 32'd0 : (w_sel_op1 << w_sel_op2[4:0]);
      default: begin
        w_alu_result = 32'd0;
        w_alu_branch = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= GNT_B;
      r_out_valid  <= 1'b0;
      r_out_result <= 32'd0;
      r_out_branch <= 1'b0;
      r_out_id     <= 1'b0;
    end else if (w_grant_any) begin
      r_last_grant <= w_grant_b ? GNT_B : GNT_A;
      r_out_valid  <= 1'b1;
      r_out_result <= w_alu_result;
      r_out_branch <= w_alu_branch;
      r_out_id     <= w_grant_b;
    end else if (w_drain) begin
      r_out_valid  <= 1'b0;
    end
  end

  // Counters track results handed to the consumer, not grants.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt_a <= 16'd0;
      r_cnt_b <= 16'd0;
    end else if (w_drain) begin
      if (r_out_id) begin
        r_cnt_b <= r_cnt_b + 16'd1;
      end else begin
        r_cnt_a <= r_cnt_a + 16'd1;
      end
    end
  end

  assign bus.a_ready    = w_grant_a;
  assign bus.b_ready    = w_grant_b;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_result = r_out_result;
  assign bus.out_branch = r_out_branch;
  assign bus.out_id     = r_out_id;
  assign bus.cnt_a      = r_cnt_a;
  assign bus.cnt_b      = r_cnt_b;

endmodule
`default_nettype wire
